// File: rtl/mbf_coeff_loader_if.sv
// rtl/mbf_coeff_loader_if.sv - coefficient configuration handshake between loader and FIR filter
interface mbf_coeff_loader_if #(
    parameter int COEFF_WIDTH = 24
);
    logic                   isConfig;
    logic                   isConfigACK;
    logic                   isConfigDone;
    logic [COEFF_WIDTH-1:0] Data_Config_Out;

    modport master (
        output isConfig,
        output Data_Config_Out,
        input  isConfigACK,
        input  isConfigDone
    );

    modport slave (
        input  isConfig,
        input  Data_Config_Out,
        output isConfigACK,
        output isConfigDone
    );
endinterface

// File: rtl/mbf_coeff_loader.sv
// rtl/mbf_coeff_loader.sv - shadow coefficient table and streaming initiator for the MBF FIR filter
module mbf_coeff_loader #(
    parameter int COEFF_WIDTH      = 24,
    parameter int FILTER_MAX_ORDER = 32,
    parameter int ADDR_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   Host_Wr_En,
    input  logic [ADDR_WIDTH-1:0]  Host_Wr_Addr,
    input  logic [COEFF_WIDTH-1:0] Host_Wr_Data,
    input  logic                   Load_Start,
    output logic                   Busy,
    output logic                   Load_Done,
    output logic                   Load_Err,
    mbf_coeff_loader_if.master     cfg
);

    localparam int NUM_WORDS = FILTER_MAX_ORDER + 2;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_WAIT_DONE,
        S_FINISH,
        S_ERR
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt, idx_inc;
    logic [TMR_W-1:0]       timer, timer_nxt, timer_inc;
    logic                   timer_hit;
    logic                   is_config_q, is_config_nxt;
    logic [COEFF_WIDTH-1:0] data_q, data_nxt;
    logic                   busy_q, busy_nxt;
    logic                   done_q, done_nxt;
    logic                   err_q, err_nxt;
    logic                   wr_ok;

    logic [COEFF_WIDTH-1:0] coeff_tab [NUM_WORDS];

    assign idx_inc   = idx + 1'b1;
    assign timer_inc = (timer == TMR_W'(TIMEOUT_CYCLES)) ? timer : timer + 1'b1;
    // The count that would be reached this edge is the one that trips the timeout,
    // so the error outputs land exactly TIMEOUT_CYCLES cycles after the wait began.
    assign timer_hit = (timer_inc == TMR_W'(TIMEOUT_CYCLES));
    assign wr_ok     = Host_Wr_En && !busy_q && (Host_Wr_Addr < ADDR_WIDTH'(NUM_WORDS));

    // Shadow table: host writes only while idle, so streamed words never change mid-load
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                coeff_tab[i] <= '0;
            end
        end else if (wr_ok) begin
            coeff_tab[IDX_W'(Host_Wr_Addr)] <= Host_Wr_Data;
        end
    end

    // State and registered-output register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            idx         <= '0;
            timer       <= '0;
            is_config_q <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            timer       <= timer_nxt;
            is_config_q <= is_config_nxt;
            data_q      <= data_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state and next-output logic; error outputs are applied on the edge that enters ERR
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        timer_nxt     = timer_inc;
        is_config_nxt = is_config_q;
        data_nxt      = data_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        err_nxt       = err_q;

        case (state)
            S_IDLE: begin
                if (Load_Start) begin
                    state_nxt     = S_REQ;
                    idx_nxt       = '0;
                    is_config_nxt = 1'b1;
                    data_nxt      = coeff_tab[0];
                    busy_nxt      = 1'b1;
                    err_nxt       = 1'b0;
                end
            end
            S_REQ: begin
                if (cfg.isConfigACK) begin
                    // Dropping the request here keeps the filter from re-entering config after Done
                    state_nxt     = S_STREAM;
                    is_config_nxt = 1'b0;
                    idx_nxt       = IDX_W'(1);
                    data_nxt      = coeff_tab[1];
                end else if (timer_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_STREAM: begin
                if (!cfg.isConfigACK) begin
                    state_nxt = S_ERR;
                end else if (idx == IDX_W'(NUM_WORDS - 1)) begin
                    state_nxt = S_WAIT_DONE;
                    data_nxt  = '0;
                end else begin
                    idx_nxt  = idx_inc;
                    data_nxt = coeff_tab[idx_inc];
                end
            end
            S_WAIT_DONE: begin
                if (cfg.isConfigDone) begin
                    state_nxt = S_FINISH;
                end else if (timer_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (state_nxt == S_ERR || state == S_ERR) begin
            is_config_nxt = 1'b0;
            data_nxt      = '0;
            err_nxt       = 1'b1;
            busy_nxt      = 1'b0;
        end

        if (state_nxt != state) begin
            timer_nxt = '0;
        end
    end

    assign Busy                = busy_q;
    assign Load_Done           = done_q;
    assign Load_Err            = err_q;
    assign cfg.isConfig        = is_config_q;
    assign cfg.Data_Config_Out = data_q;

endmodule
